// File: rtl/dram_read_scheduler.sv
// dram_read_scheduler: issues 24-bit chunk read addresses for every voice.
// Each voice walks its own chunk region; per-voice credits cap the chunks in
// flight, and a round-robin arbiter shares the single request channel.
module dram_read_scheduler #(
  parameter int INSTRUMENT_COUNT = 8,
  parameter int CREDITS          = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INSTRUMENT_COUNT:0][23:0]    addr_offsets,
  input  logic                               addr_offsets_valid,
  input  logic [INSTRUMENT_COUNT-1:0]        trigger,
  input  logic [INSTRUMENT_COUNT-1:0]        chunk_consumed,
  output logic                               req_tvalid,
  input  logic                               req_tready,
  output logic [23:0]                        req_tdata,
  output logic [INSTRUMENT_COUNT-1:0]        active,
  output logic                               busy
);

  localparam int VID_W = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
  localparam int OUT_W = $clog2(CREDITS + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t                      state_r;
  logic                        req_tvalid_r;
  logic [23:0]                 req_tdata_r;
  logic [VID_W-1:0]            req_vid_r;
  logic [VID_W-1:0]            last_grant_r;
  logic [INSTRUMENT_COUNT-1:0] active_r;
  logic [23:0]                 next_addr_r     [INSTRUMENT_COUNT];
  logic [OUT_W-1:0]            outstanding_r   [INSTRUMENT_COUNT];
  logic                        busy_r;

  logic [INSTRUMENT_COUNT-1:0] eligible_s;
  logic                        grant_any_s;
  logic [VID_W-1:0]            grant_vid_s;
  logic [VID_W-1:0]            cand_s;
  logic                        handshake_s;
  logic [INSTRUMENT_COUNT-1:0] trig_ok_s;
  logic [INSTRUMENT_COUNT-1:0] hs_vid_s;
  logic [INSTRUMENT_COUNT-1:0] consume_s;
  logic [INSTRUMENT_COUNT-1:0] active_nxt_s;
  logic [23:0]                 next_addr_nxt_s [INSTRUMENT_COUNT];
  logic [OUT_W-1:0]            outstanding_nxt_s [INSTRUMENT_COUNT];
  logic                        req_tvalid_nxt_s;
  logic                        busy_nxt_s;

  // Eligibility and round-robin pick; scanning from the far end lets the
  // voice nearest to last_grant+1 overwrite the others.
  always_comb begin
    eligible_s  = '0;
    grant_any_s = 1'b0;
    grant_vid_s = '0;
    cand_s      = '0;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      eligible_s[i] = active_r[i] && (outstanding_r[i] < OUT_W'(CREDITS)) && addr_offsets_valid;
    end
    for (int k = INSTRUMENT_COUNT; k >= 1; k--) begin
      cand_s      = VID_W'((int'(last_grant_r) + k) % INSTRUMENT_COUNT);
      grant_vid_s = eligible_s[cand_s] ? cand_s : grant_vid_s;
      grant_any_s = grant_any_s | eligible_s[cand_s];
    end
  end

  // Per-voice next state: trigger beats handshake for address/active,
  // credits move by handshake minus (saturating) consumption.
  always_comb begin
    handshake_s  = req_tvalid_r & req_tready;
    trig_ok_s    = '0;
    hs_vid_s     = '0;
    consume_s    = '0;
    active_nxt_s = active_r;
    busy_nxt_s   = 1'b0;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      next_addr_nxt_s[i]   = next_addr_r[i];
      outstanding_nxt_s[i] = outstanding_r[i];
      trig_ok_s[i] = trigger[i] && addr_offsets_valid && (addr_offsets[i] < addr_offsets[i+1]);
      hs_vid_s[i]  = handshake_s && (req_vid_r == VID_W'(i));
      consume_s[i] = chunk_consumed[i] && (outstanding_r[i] != '0);
      if (trig_ok_s[i]) begin
        active_nxt_s[i]    = 1'b1;
        next_addr_nxt_s[i] = addr_offsets[i];
      end else if (hs_vid_s[i]) begin
        next_addr_nxt_s[i] = next_addr_r[i] + 24'd1;
        active_nxt_s[i]    = ((next_addr_r[i] + 24'd1) == addr_offsets[i+1]) ? 1'b0 : active_r[i];
      end else begin
        active_nxt_s[i]    = active_r[i];
      end
      case ({hs_vid_s[i], consume_s[i]})
        2'b10:   outstanding_nxt_s[i] = outstanding_r[i] + OUT_W'(1);
        2'b01:   outstanding_nxt_s[i] = outstanding_r[i] - OUT_W'(1);
        default: outstanding_nxt_s[i] = outstanding_r[i];
      endcase
      busy_nxt_s = busy_nxt_s | (outstanding_nxt_s[i] != '0);
    end
    case (state_r)
      ST_IDLE: req_tvalid_nxt_s = grant_any_s;
      ST_PEND: req_tvalid_nxt_s = !handshake_s;
      default: req_tvalid_nxt_s = 1'b0;
    endcase
    busy_nxt_s = busy_nxt_s | (|active_nxt_s) | req_tvalid_nxt_s;
  end

  // Request FSM plus all per-voice state; every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      req_tvalid_r <= 1'b0;
      req_tdata_r  <= 24'd0;
      req_vid_r    <= '0;
      last_grant_r <= VID_W'(INSTRUMENT_COUNT - 1);
      active_r     <= '0;
      busy_r       <= 1'b0;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        next_addr_r[i]   <= 24'd0;
        outstanding_r[i] <= '0;
      end
    end else begin
      active_r <= active_nxt_s;
      busy_r   <= busy_nxt_s;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        next_addr_r[i]   <= next_addr_nxt_s[i];
        outstanding_r[i] <= outstanding_nxt_s[i];
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            req_tvalid_r <= 1'b1;
            req_tdata_r  <= next_addr_r[grant_vid_s];
            req_vid_r    <= grant_vid_s;
            state_r      <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (handshake_s) begin
            req_tvalid_r <= 1'b0;
            last_grant_r <= req_vid_r;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          req_tvalid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_tvalid = req_tvalid_r;
  assign req_tdata  = req_tdata_r;
  assign active     = active_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dram_read_scheduler.sv
// Directed bench for dram_read_scheduler: a queue of expected request
// addresses is filled as stimulus is applied and drained on each handshake.
module tb_dram_read_scheduler;

  localparam int N = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N:0][23:0]     offs;
  logic                 offs_valid = 1'b1;
  logic [N-1:0]         trigger = '0;
  logic [N-1:0]         chunk_consumed = '0;
  logic                 req_tvalid;
  logic                 req_tready = 1'b0;
  logic [23:0]          req_tdata;
  logic [N-1:0]         active;
  logic                 busy;

  int                   checks = 0;
  int                   errors = 0;
  int                   hs_cnt = 0;
  int                   hs0;
  logic [23:0]          exp_q[$];
  logic [23:0]          mon_exp;

  dram_read_scheduler #(.INSTRUMENT_COUNT(N), .CREDITS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .addr_offsets       (offs),
    .addr_offsets_valid (offs_valid),
    .trigger            (trigger),
    .chunk_consumed     (chunk_consumed),
    .req_tvalid         (req_tvalid),
    .req_tready         (req_tready),
    .req_tdata          (req_tdata),
    .active             (active),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic default_offsets();
    for (int i = 0; i <= N; i++) offs[i] = 24'(i * 32'h1000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    step(1);
  endtask

  // Scoreboard: every handshake must match the oldest expected address.
  always @(negedge clk) begin
    if (!rst && req_tvalid && req_tready) begin
      hs_cnt++;
      chk("hs_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("hs_addr", 32'(req_tdata), 32'(mon_exp));
      end
    end
  end

  initial begin
    default_offsets();
    step(2);
    chk("rst_tvalid", 32'(req_tvalid), 32'd0);
    chk("rst_tdata", 32'(req_tdata), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(1);

    // Single voice, three-chunk region
    offs[0] = 24'h000100;
    offs[1] = 24'h000103;
    req_tready = 1'b1;
    exp_q.push_back(24'h100); exp_q.push_back(24'h101); exp_q.push_back(24'h102);
    trigger = 8'h01;
    step(1);
    trigger = 8'h00;
    chk("sv_active_t1", 32'(active[0]), 32'd1);
    chk("sv_tvalid_t1", 32'(req_tvalid), 32'd0);
    step(1);
    chk("sv_tvalid_t2", 32'(req_tvalid), 32'd1);
    chk("sv_tdata_t2", 32'(req_tdata), 32'h100);
    step(1);
    chk("sv_tvalid_t3", 32'(req_tvalid), 32'd0);
    step(1);
    chk("sv_tdata_t4", 32'(req_tdata), 32'h101);
    chk("sv_tvalid_t4", 32'(req_tvalid), 32'd1);
    step(2);
    chk("sv_tdata_t6", 32'(req_tdata), 32'h102);
    chk("sv_tvalid_t6", 32'(req_tvalid), 32'd1);
    step(1);
    chk("sv_active_end", 32'(active[0]), 32'd0);
    chk("sv_busy_outst", 32'(busy), 32'd1);
    step(3);
    chk("sv_no_more", 32'(req_tvalid), 32'd0);
    chk("sv_q_empty", 32'(exp_q.size()), 32'd0);
    chunk_consumed = 8'h01;
    step(2);
    chunk_consumed = 8'h00;
    chk("sv_busy_one_left", 32'(busy), 32'd1);
    chunk_consumed = 8'h01;
    step(1);
    chunk_consumed = 8'h00;
    chk("sv_busy_drained", 32'(busy), 32'd0);

    // Credit stall on a ten-chunk region
    do_reset();
    offs[0] = 24'h000200;
    offs[1] = 24'h00020A;
    for (int a = 0; a < 4; a++) exp_q.push_back(24'(32'h200 + a));
    hs0 = hs_cnt;
    trigger = 8'h01;
    step(1);
    trigger = 8'h00;
    step(30);
    chk("cs_count4", 32'(hs_cnt - hs0), 32'd4);
    chk("cs_stalled", 32'(req_tvalid), 32'd0);
    chk("cs_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(24'h204);
    chunk_consumed = 8'h01;
    step(1);
    chunk_consumed = 8'h00;
    step(10);
    chk("cs_count5", 32'(hs_cnt - hs0), 32'd5);
    chk("cs_stalled2", 32'(req_tvalid), 32'd0);
    chk("cs_q_empty2", 32'(exp_q.size()), 32'd0);

    // Round-robin among voices 0, 2, 5
    default_offsets();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(24'(32'h0000 + r));
      exp_q.push_back(24'(32'h2000 + r));
      exp_q.push_back(24'(32'h5000 + r));
    end
    hs0 = hs_cnt;
    trigger = 8'b0010_0101;
    step(1);
    trigger = 8'h00;
    step(40);
    chk("rr_count12", 32'(hs_cnt - hs0), 32'd12);
    chk("rr_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rr_stalled", 32'(req_tvalid), 32'd0);

    // Backpressure on voice 3, then reset while a request is pending
    do_reset();
    req_tready = 1'b0;
    exp_q.push_back(24'h3000); exp_q.push_back(24'h3001);
    trigger = 8'h08;
    step(1);
    trigger = 8'h00;
    step(1);
    for (int c = 0; c < 20; c++) begin
      chk("bp_tvalid_hold", 32'(req_tvalid), 32'd1);
      chk("bp_tdata_hold", 32'(req_tdata), 32'h3000);
      step(1);
    end
    req_tready = 1'b1;
    step(1);
    chk("bp_released", 32'(req_tvalid), 32'd0);
    chk("bp_q_one_left", 32'(exp_q.size()), 32'd1);
    step(1);
    chk("bp_next_addr", 32'(req_tdata), 32'h3001);
    step(1);
    req_tready = 1'b0;
    step(1);
    chk("bp_pend_again", 32'(req_tvalid), 32'd1);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_tvalid", 32'(req_tvalid), 32'd0);
    chk("mr_tdata", 32'(req_tdata), 32'd0);
    chk("mr_active", 32'(active), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

    // Boundaries: empty region and invalid offsets
    offs[5] = offs[4];
    req_tready = 1'b1;
    trigger = 8'h10;
    step(1);
    trigger = 8'h00;
    chk("bd_empty_active", 32'(active), 32'd0);
    step(3);
    chk("bd_empty_tvalid", 32'(req_tvalid), 32'd0);
    chk("bd_empty_busy", 32'(busy), 32'd0);
    default_offsets();
    offs_valid = 1'b0;
    trigger = 8'h02;
    step(1);
    trigger = 8'h00;
    chk("bd_inval_active", 32'(active), 32'd0);
    offs_valid = 1'b1;
    step(3);
    chk("bd_inval_tvalid", 32'(req_tvalid), 32'd0);
    chk("bd_inval_active2", 32'(active), 32'd0);

    // Retrigger voice 1 on its handshake cycle
    do_reset();
    hs0 = hs_cnt;
    exp_q.push_back(24'h1000);
    trigger = 8'h02;
    step(1);
    trigger = 8'h00;
    step(1);
    chk("rt_first", 32'(req_tdata), 32'h1000);
    chk("rt_first_valid", 32'(req_tvalid), 32'd1);
    exp_q.push_back(24'h1000);
    exp_q.push_back(24'h1001);
    exp_q.push_back(24'h1002);
    trigger = 8'h02;
    step(1);
    trigger = 8'h00;
    step(30);
    chk("rt_count4", 32'(hs_cnt - hs0), 32'd4);
    chk("rt_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rt_stalled", 32'(req_tvalid), 32'd0);
    chk("rt_still_active", 32'(active[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_read_scheduler.md
# dram_read_scheduler

Issues 24-bit chunk read addresses toward the DRAM read controller on behalf of every instrument voice, one 128-bit chunk (eight 16-bit samples) per request. It sits upstream of the DRAM read FIFO and the per-instrument unstackers. It tracks each voice's playback address and limits outstanding chunks per voice with credits, so no voice can monopolise the shared read FIFO. It shares the single request channel between voices with round-robin arbitration.

## Interface
- INSTRUMENT_COUNT, 8: number of voices.
- CREDITS, 4: maximum chunks requested but not yet consumed, per voice.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- addr_offsets  in  24 x [INSTRUMENT_COUNT:0]  chunk-granular region bounds; voice i owns [addr_offsets[i], addr_offsets[i+1]).
- addr_offsets_valid  in  1  the bounds are loaded and stable.
- trigger  in  INSTRUMENT_COUNT  one-cycle pulse per voice: start playback from the region start.
- chunk_consumed  in  INSTRUMENT_COUNT  per-voice pulse when that voice's unstacker accepts a chunk (chunk_tvalid & chunk_tready); returns one credit.
- req_tvalid  out  1  read request valid.
- req_tready  in  1  the DRAM controller accepts the request.
- req_tdata  out  24  chunk address to read.
- active  out  INSTRUMENT_COUNT  voice still has chunks left to request.
- busy  out  1  any active bit set, any outstanding count nonzero, or req_tvalid high.

## Operation
- Per-voice registers: active, next_addr[23:0], outstanding[$clog2(CREDITS+1)-1:0].
- Trigger handling for voice i:
  - Accepted only if addr_offsets_valid is high and addr_offsets[i] < addr_offsets[i+1]; otherwise ignored.
  - On acceptance, next_addr <= addr_offsets[i] and active <= 1.
  - Outstanding is not cleared; chunks already in flight still return their credits.
  - Retrigger while active simply restarts playback.
- Eligibility: active[i] && outstanding[i] < CREDITS && addr_offsets_valid.
- Arbiter:
  - Round-robin. The search starts at last_grant+1 and wraps modulo INSTRUMENT_COUNT.
  - last_grant resets to INSTRUMENT_COUNT-1, so voice 0 has first priority.
- Request register (two states):
  - IDLE: if any voice is eligible, load req_tdata = next_addr[g] and req_vid = g, raise req_tvalid, and move to PEND.
  - PEND: hold req_tvalid, req_tdata and req_vid stable until req_tready.
  - On handshake (req_tvalid & req_tready):
    - outstanding[g]++ and last_grant <= g.
    - If no trigger for g in the same cycle: next_addr[g]++, and if next_addr[g]+1 == addr_offsets[g+1] then active[g] <= 0 (last chunk issued).
    - Return to IDLE. No back-to-back issue: at most one request every 2 cycles.
- Simultaneous events:
  - Handshake and chunk_consumed for the same voice in one cycle: outstanding unchanged.
  - chunk_consumed while outstanding == 0: ignored (saturating).
  - Trigger for voice g in the same cycle as g's handshake: the trigger wins for next_addr and active. Outstanding still increments.
- addr_offsets_valid falling low:
  - A held PEND request completes normally.
  - No new grants are made.
  - Active bits are retained.

## Timing
- Reset values: req_tvalid 0, req_tdata 0, active 0, busy 0. All outstanding counts 0, every next_addr 0, FSM in IDLE.
- Trigger at cycle t: active high at t+1, req_tvalid high at t+2 at the earliest.
- Handshake at cycle t: outstanding visible at t+1, next grant loaded at t+1, req_tvalid high again at t+2.
- chunk_consumed at t: the credit is usable for a grant evaluated at t+1.
- The grant decision is combinational from registered state. All outputs are registered.
- Reset asserted mid-PEND: req_tvalid drops immediately (asynchronous). The DRAM controller must tolerate a withdrawn request under reset.

## Test plan
- Single voice:
  - Stimulus: offsets[0]=0x100, offsets[1]=0x103, CREDITS=4, req_tready=1, trigger[0].
  - Required: requests 0x100, 0x101, 0x102 at cycles t+2, t+4, t+6; active[0] falls after the third handshake; outstanding[0]=3.
- Credit stall:
  - Stimulus: region of 10 chunks, no chunk_consumed.
  - Required: exactly 4 requests issue, then req_tvalid stays low.
  - Then: one chunk_consumed pulse produces exactly one more request, address base+4.
- Round-robin:
  - Stimulus: voices 0, 2 and 5 triggered in the same cycle, large regions, req_tready=1.
  - Required: grant order 0, 2, 5, 0, 2, 5…; each voice's addresses strictly increment from its own offset.
- Backpressure:
  - Stimulus: req_tready held low for 20 cycles.
  - Required: req_tdata and req_tvalid stable throughout; one handshake when req_tready rises; no address skipped.
- Boundaries:
  - Stimulus: trigger a voice with an empty region (offsets equal); separately, trigger while addr_offsets_valid=0.
  - Required: both triggers are ignored and active stays 0.
- Retrigger and reset:
  - Retrigger voice 1 on its handshake cycle: next request is addr_offsets[1], and outstanding still counts the in-flight chunk.
  - rst pulse mid-PEND: all outputs return to their reset values at once.
